// File: rtl/vscale_hasti_mp_sram_if.sv
// Flattened N-port HASTI bus bundle: port i occupies slice [i*W +: W] of every vector.
interface vscale_hasti_mp_sram_if #(
    parameter int N_PORTS = 2
);
    logic [N_PORTS*32-1:0] p_haddr;
    logic [N_PORTS-1:0]    p_hwrite;
    logic [N_PORTS*3-1:0]  p_hsize;
    logic [N_PORTS*3-1:0]  p_hburst;
    logic [N_PORTS-1:0]    p_hmastlock;
    logic [N_PORTS*4-1:0]  p_hprot;
    logic [N_PORTS*2-1:0]  p_htrans;
    logic [N_PORTS*32-1:0] p_hwdata;
    logic [N_PORTS*32-1:0] p_hrdata;
    logic [N_PORTS-1:0]    p_hready;
    logic [N_PORTS-1:0]    p_hresp;

    modport master (
        output p_haddr, p_hwrite, p_hsize, p_hburst, p_hmastlock, p_hprot, p_htrans, p_hwdata,
        input  p_hrdata, p_hready, p_hresp
    );
    modport slave (
        input  p_haddr, p_hwrite, p_hsize, p_hburst, p_hmastlock, p_hprot, p_htrans, p_hwdata,
        output p_hrdata, p_hready, p_hresp
    );
endinterface

// File: rtl/vscale_hasti_mp_sram.sv
// N-port HASTI SRAM: one shared bank, round-robin grant, programmable wait states, byte lanes.
// Define VSCALE_SRAM_ERR_RESP_EN to answer out-of-range addresses with a two-cycle ERROR.
module vscale_hasti_mp_sram_port #(
    parameter int AW          = 14,
    parameter int WAIT_STATES = 0
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic [31:0]   haddr_i,
    input  logic          hwrite_i,
    input  logic [2:0]    hsize_i,
    input  logic          hvalid_i,
    input  logic          grant_i,
    output logic          elig_o,
    output logic          hready_o,
    output logic          hresp_o,
    output logic          wr_o,
    output logic [AW-1:0] word_o,
    output logic [3:0]    lanes_o
);
    typedef enum logic {S_IDLE, S_PEND} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] word_q, word_d;
    logic [1:0]    off_q, off_d;
    logic [2:0]    size_q, size_d;
    logic          wr_q, wr_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic          accept, done, err_act, err_done;

    assign accept   = hvalid_i && hready_o;
    assign done     = grant_i || err_done;
    assign hready_o = (state_q == S_IDLE) || done;
    assign elig_o   = (state_q == S_PEND) && (wcnt_q == '0) && !err_act;
    assign wr_o     = wr_q;
    assign word_o   = word_q;

`ifdef VSCALE_SRAM_ERR_RESP_EN
    logic err_q, errph_q;
    // errph_q marks the second (hready high) cycle of the ERROR response
    assign err_act  = (state_q == S_PEND) && (wcnt_q == '0) && err_q;
    assign err_done = err_act && errph_q;
    assign hresp_o  = err_act;
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            err_q   <= 1'b0;
            errph_q <= 1'b0;
        end else begin
            errph_q <= err_act && !errph_q;
            if (accept) err_q <= (haddr_i >> (AW + 2)) != '0;
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^haddr_i;
    assign err_act   = 1'b0;
    assign err_done  = 1'b0;
    assign hresp_o   = 1'b0;
`endif

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            wr_q    <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            off_q   <= off_d;
            size_q  <= size_d;
            wr_q    <= wr_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        off_d   = off_q;
        size_d  = size_q;
        wr_d    = wr_q;
        wcnt_d  = wcnt_q;
        if (state_q == S_PEND && wcnt_q != '0) wcnt_d = wcnt_q - 4'd1;
        if (done) state_d = S_IDLE;
        // a new address phase may be captured in the same cycle the previous one completes
        if (accept) begin
            state_d = S_PEND;
            word_d  = haddr_i[AW+1:2];
            off_d   = haddr_i[1:0];
            size_d  = hsize_i;
            wr_d    = hwrite_i;
            wcnt_d  = 4'(WAIT_STATES);
        end
    end

    always_comb begin
        lanes_o = 4'b1111;
        if (size_q == 3'd0)      lanes_o = 4'b0001 << off_q;
        else if (size_q == 3'd1) lanes_o = off_q[1] ? 4'b1100 : 4'b0011;
    end
endmodule

module vscale_hasti_mp_sram #(
    parameter int N_PORTS     = 2,
    parameter int DEPTH_WORDS = 16384,
    parameter int WAIT_STATES = 0
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    vscale_hasti_mp_sram_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int RW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [31:0] mem [DEPTH_WORDS];

    logic [N_PORTS-1:0]         elig, grant, wr, rdy, rsp;
    logic [N_PORTS-1:0][AW-1:0] word;
    logic [N_PORTS-1:0][3:0]    lanes;
    logic [N_PORTS-1:0][31:0]   rdata;
    logic [RW-1:0]              rr_q, rr_d;
    logic                       found;
    int                         idx;
    logic                       wr_en;
    logic [AW-1:0]              wr_word;
    logic [3:0]                 wr_be;
    logic [31:0]                wr_data;
    logic                       unused_in;

    assign unused_in = ^{bus.p_hburst, bus.p_hmastlock, bus.p_hprot, bus.p_htrans};

    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        vscale_hasti_mp_sram_port #(.AW(AW), .WAIT_STATES(WAIT_STATES)) u_port (
            .hclk     (hclk),
            .hresetn  (hresetn),
            .haddr_i  (bus.p_haddr[i*32 +: 32]),
            .hwrite_i (bus.p_hwrite[i]),
            .hsize_i  (bus.p_hsize[i*3 +: 3]),
            .hvalid_i (bus.p_htrans[i*2+1]),
            .grant_i  (grant[i]),
            .elig_o   (elig[i]),
            .hready_o (rdy[i]),
            .hresp_o  (rsp[i]),
            .wr_o     (wr[i]),
            .word_o   (word[i]),
            .lanes_o  (lanes[i])
        );
    end

    assign bus.p_hready = rdy;
    assign bus.p_hresp  = rsp;
    assign bus.p_hrdata = rdata;

    // round-robin: first eligible port at or after rr_q wins the bank
    always_comb begin
        grant = '0;
        rr_d  = rr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_PORTS; k++) begin
            idx = (int'(rr_q) + k) % N_PORTS;
            if (!found && elig[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                rr_d       = RW'((idx + 1) % N_PORTS);
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) rr_q <= '0;
        else          rr_q <= rr_d;
    end

    always_comb begin
        rdata   = '0;
        wr_en   = 1'b0;
        wr_word = '0;
        wr_be   = '0;
        wr_data = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant[i] && !wr[i]) rdata[i] = mem[word[i]];
            if (grant[i] && wr[i]) begin
                wr_en   = 1'b1;
                wr_word = word[i];
                wr_be   = lanes[i];
                wr_data = bus.p_hwdata[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (wr_en)
            for (int b = 0; b < 4; b++)
                if (wr_be[b]) mem[wr_word][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
endmodule

// File: tb/tb_vscale_hasti_mp_sram.sv
// Directed bench: dut_a (3 ports, 0 wait states) and dut_b (1 port, 3 wait states) with a per-port scoreboard.
module tb_vscale_hasti_mp_sram;
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2;
`ifdef VSCALE_SRAM_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic hclk = 1'b0;
    logic hresetn;
    always #5 hclk = ~hclk;

    vscale_hasti_mp_sram_if #(.N_PORTS(3)) a ();
    vscale_hasti_mp_sram_if #(.N_PORTS(1)) b ();

    vscale_hasti_mp_sram #(.N_PORTS(3), .DEPTH_WORDS(4096), .WAIT_STATES(0)) dut_a (
        .hclk(hclk), .hresetn(hresetn), .bus(a));
    vscale_hasti_mp_sram #(.N_PORTS(1), .DEPTH_WORDS(1024), .WAIT_STATES(3)) dut_b (
        .hclk(hclk), .hresetn(hresetn), .bus(b));

    typedef struct {
        logic        rd;
        logic [31:0] data;
        int          waits;
        logic        resp;
    } exp_t;

    int   checks = 0, errors = 0;
    exp_t qa [3][$];
    exp_t qb [$];
    logic [2:0]  dpa;
    int          wca [3];
    logic        dpb;
    int          wcb;
    logic [31:0] pre [3] = '{32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input int waits, input logic resp,
                       input logic [31:0] rdata);
        chk({tag, " waits"}, 32'(waits), 32'(e.waits));
        chk({tag, " hresp"}, {31'b0, resp}, {31'b0, e.resp});
        if (e.rd) chk({tag, " rdata"}, rdata, e.data);
    endtask

    // scoreboard: a data phase ends on the first hready-high cycle after its address was accepted
    always @(negedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dpa = '0;
            dpb = 1'b0;
            wcb = 0;
            qb.delete();
            for (int i = 0; i < 3; i++) begin
                qa[i].delete();
                wca[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (dpa[i]) begin
                    if (!a.p_hready[i]) begin
                        wca[i]++;
                        chk($sformatf("a%0d stall rdata", i), a.p_hrdata[i*32 +: 32], 32'h0);
                    end else begin
                        checks++;
                        assert (qa[i].size() != 0) else begin
                            errors++;
                            $error("FAIL a%0d completion: observed unexpected expected none", i);
                        end
                        if (qa[i].size() != 0)
                            cmp($sformatf("a%0d", i), qa[i].pop_front(), wca[i], a.p_hresp[i],
                                a.p_hrdata[i*32 +: 32]);
                        wca[i] = 0;
                    end
                end
                dpa[i] = (a.p_htrans[2*i+1] && a.p_hready[i]) || (dpa[i] && !a.p_hready[i]);
            end
            if (dpb) begin
                if (!b.p_hready[0]) begin
                    wcb++;
                    chk("b stall rdata", b.p_hrdata, 32'h0);
                end else begin
                    checks++;
                    assert (qb.size() != 0) else begin
                        errors++;
                        $error("FAIL b completion: observed unexpected expected none");
                    end
                    if (qb.size() != 0) cmp("b", qb.pop_front(), wcb, b.p_hresp[0], b.p_hrdata);
                    wcb = 0;
                end
            end
            dpb = (b.p_htrans[1] && b.p_hready[0]) || (dpb && !b.p_hready[0]);
        end
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic a_drv(input int p, input logic [1:0] tr, input logic w, input logic [2:0] sz,
                         input logic [31:0] ad);
        a.p_htrans[2*p +: 2] = tr;
        a.p_hwrite[p]        = w;
        a.p_hsize[3*p +: 3]  = sz;
        a.p_haddr[32*p +: 32] = ad;
    endtask

    task automatic a_wd(input int p, input logic [31:0] d);
        a.p_hwdata[32*p +: 32] = d;
    endtask

    task automatic a_exp(input int p, input logic rd, input logic [31:0] d, input int w, input logic r);
        exp_t e;
        e.rd = rd; e.data = d; e.waits = w; e.resp = r;
        qa[p].push_back(e);
    endtask

    task automatic b_drv(input logic [1:0] tr, input logic w, input logic [2:0] sz, input logic [31:0] ad);
        b.p_htrans = tr;
        b.p_hwrite = w;
        b.p_hsize  = sz;
        b.p_haddr  = ad;
    endtask

    task automatic b_exp(input logic rd, input logic [31:0] d, input int w, input logic r);
        exp_t e;
        e.rd = rd; e.data = d; e.waits = w; e.resp = r;
        qb.push_back(e);
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, " a hready"}, 32'(a.p_hready), 32'h7);
        chk({tag, " a hresp"}, 32'(a.p_hresp), 32'h0);
        chk({tag, " a hrdata"}, {31'b0, |a.p_hrdata}, 32'h0);
        chk({tag, " b hready"}, 32'(b.p_hready), 32'h1);
        chk({tag, " b hresp"}, 32'(b.p_hresp), 32'h0);
        chk({tag, " b hrdata"}, b.p_hrdata, 32'h0);
    endtask

    initial begin
        hresetn = 1'b0;
        a.p_haddr = '0; a.p_hwrite = '0; a.p_hsize = '0; a.p_hburst = '0;
        a.p_hmastlock = '0; a.p_hprot = '0; a.p_htrans = '0; a.p_hwdata = '0;
        b.p_haddr = '0; b.p_hwrite = '0; b.p_hsize = '0; b.p_hburst = '0;
        b.p_hmastlock = '0; b.p_hprot = '0; b.p_htrans = '0; b.p_hwdata = '0;
        repeat (2) tick();
        rst_chk("reset");
        hresetn = 1'b1;
        tick();

        // single port pipelined word/byte/half writes with readback, zero wait
        a_drv(0, NONSEQ, 1, 2, 32'h1000); a_exp(0, 0, 0, 0, 0); tick();
        a_wd(0, 32'hDEADBEEF); a_drv(0, NONSEQ, 0, 2, 32'h1000); a_exp(0, 1, 32'hDEADBEEF, 0, 0); tick();
        a_drv(0, NONSEQ, 1, 0, 32'h1002); a_exp(0, 0, 0, 0, 0); tick();
        a_wd(0, 32'h0055_0000); a_drv(0, NONSEQ, 0, 2, 32'h1000); a_exp(0, 1, 32'hDE55BEEF, 0, 0); tick();
        a_drv(0, NONSEQ, 1, 1, 32'h1002); a_exp(0, 0, 0, 0, 0); tick();
        a_wd(0, 32'h1234_0000); a_drv(0, NONSEQ, 0, 2, 32'h1000); a_exp(0, 1, 32'h1234BEEF, 0, 0); tick();
        a_drv(0, NONSEQ, 1, 1, 32'h1000); a_exp(0, 0, 0, 0, 0); tick();
        a_wd(0, 32'h0000_ABCD); a_drv(0, NONSEQ, 0, 2, 32'h1000); a_exp(0, 1, 32'h1234ABCD, 0, 0); tick();
        a_drv(0, NONSEQ, 1, 0, 32'h1003); a_exp(0, 0, 0, 0, 0); tick();
        a_wd(0, 32'h7700_0000); a_drv(0, NONSEQ, 0, 2, 32'h1000); a_exp(0, 1, 32'h7734ABCD, 0, 0); tick();
        a_drv(0, IDLE, 0, 0, 0); a_drv(1, BUSY, 0, 2, 32'h1000); tick();
        chk("busy hready", 32'(a.p_hready[1]), 32'h1);
        chk("busy hresp", 32'(a.p_hresp[1]), 32'h0);
        a_drv(1, IDLE, 0, 0, 0); tick();

        // preload through port 2 so its last grant returns the rr pointer to 0
        a_drv(2, NONSEQ, 1, 2, 32'h2000); a_exp(2, 0, 0, 0, 0); tick();
        a_wd(2, pre[0]); a_drv(2, NONSEQ, 1, 2, 32'h2004); a_exp(2, 0, 0, 0, 0); tick();
        a_wd(2, pre[1]); a_drv(2, NONSEQ, 1, 2, 32'h2008); a_exp(2, 0, 0, 0, 0); tick();
        a_wd(2, pre[2]); a_drv(2, IDLE, 0, 0, 0); tick();

        // same-cycle contention, twice: grant order 0,1,2 both times
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 3; p++) begin
                a_drv(p, NONSEQ, 0, 2, 32'h2000 + 32'(4 * p));
                a_exp(p, 1, pre[p], p, 0);
            end
            tick();
            for (int p = 0; p < 3; p++) a_drv(p, IDLE, 0, 0, 0);
            repeat (4) tick();
        end

        // port 0 write granted at t, port 1 read of same word granted at t+1
        a_drv(0, NONSEQ, 1, 2, 32'h2010); a_exp(0, 0, 0, 0, 0);
        a_drv(1, NONSEQ, 0, 2, 32'h2010); a_exp(1, 1, 32'hC0FFEE00, 1, 0); tick();
        a_drv(0, IDLE, 0, 0, 0); a_drv(1, IDLE, 0, 0, 0); a_wd(0, 32'hC0FFEE00);
        repeat (3) tick();

        // out-of-range on dut_a: 0x4000 aliases word 0 or errors
        a_drv(0, NONSEQ, 1, 2, 32'h0); a_exp(0, 0, 0, 0, 0); tick();
        a_wd(0, 32'h600DCAFE); a_drv(0, IDLE, 0, 0, 0); tick();
        a_drv(0, NONSEQ, 1, 2, 32'h4000); a_exp(0, 0, 0, ERR_EN ? 1 : 0, ERR_EN); tick();
        a_wd(0, 32'h0BADF00D); a_drv(0, IDLE, 0, 0, 0);
        chk("oor cycle1 hready", 32'(a.p_hready[0]), ERR_EN ? 32'h0 : 32'h1);
        chk("oor cycle1 hresp", 32'(a.p_hresp[0]), ERR_EN ? 32'h1 : 32'h0);
        repeat (3) tick();
        a_drv(0, NONSEQ, 0, 2, 32'h0); a_exp(0, 1, ERR_EN ? 32'h600DCAFE : 32'h0BADF00D, 0, 0); tick();
        a_drv(0, IDLE, 0, 0, 0); repeat (2) tick();

        // dut_b: three wait states, held back-to-back reads
        b_drv(NONSEQ, 1, 2, 32'h0); b_exp(0, 0, 3, 0); tick();
        b.p_hwdata = 32'h12345678; b_drv(IDLE, 0, 0, 0); repeat (5) tick();
        b_drv(NONSEQ, 0, 2, 32'h0); b_exp(1, 32'h12345678, 3, 0); tick();
        b_exp(1, 32'h12345678, 3, 0); repeat (4) tick();
        b_drv(IDLE, 0, 0, 0); repeat (6) tick();

        // out-of-range on dut_b: 0x1000 with 1024 words
        b_drv(NONSEQ, 1, 2, 32'h1000); b_exp(0, 0, ERR_EN ? 4 : 3, ERR_EN); tick();
        b.p_hwdata = 32'hFEEDFACE; b_drv(IDLE, 0, 0, 0); repeat (7) tick();
        b_drv(NONSEQ, 0, 2, 32'h0); b_exp(1, ERR_EN ? 32'h12345678 : 32'hFEEDFACE, 3, 0); tick();
        b_drv(IDLE, 0, 0, 0); repeat (6) tick();

        // reset during a's grant cycle and b's wait states: nothing lands
        a_drv(0, NONSEQ, 1, 2, 32'h2000); b_drv(NONSEQ, 1, 2, 32'h0); tick();
        a_drv(0, IDLE, 0, 0, 0); b_drv(IDLE, 0, 0, 0);
        a_wd(0, 32'hFFFFFFFF); b.p_hwdata = 32'hFFFFFFFF;
        #2 hresetn = 1'b0;
        #1 rst_chk("midreset");
        tick();
        hresetn = 1'b1;
        tick();
        a_drv(0, NONSEQ, 0, 2, 32'h2000); a_exp(0, 1, pre[0], 0, 0);
        b_drv(NONSEQ, 0, 2, 32'h0); b_exp(1, ERR_EN ? 32'h12345678 : 32'hFEEDFACE, 3, 0); tick();
        a_drv(0, IDLE, 0, 0, 0); b_drv(IDLE, 0, 0, 0);
        repeat (8) tick();

        for (int p = 0; p < 3; p++) chk($sformatf("a%0d drained", p), 32'(qa[p].size()), 32'h0);
        chk("b drained", 32'(qb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
